// File: rtl/rv_decode_pkg.sv
// rtl/rv_decode_pkg.sv - shared types and opcode constants for the RV decode stage
//
// Purpose: format codes and base opcode values used by the decode stage and
// its immediate generator.
// Ports: none (package).

package rv_decode_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

endpackage

// File: rtl/rv_decode_stage_imm_gen.sv
// rtl/rv_decode_stage_imm_gen.sv - combinational format classifier and immediate generator
//
// Purpose: maps an instruction to its format, sign-extended immediate,
// register-usage flags and illegal indication.
// Ports:
//   inst      in   32    raw instruction
//   fmt       out  3     format code (FMT_NONE when illegal)
//   imm       out  XLEN  sign-extended immediate (0 for R/NONE)
//   rd_we     out  1     writes a non-zero rd
//   rs1_used  out  1     reads rs1
//   rs2_used  out  1     reads rs2
//   illegal   out  1     unsupported encoding

module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output fmt_t            fmt,
  output logic [XLEN-1:0] imm,
  output logic            rd_we,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic            illegal
);

  always_comb begin
    fmt = FMT_NONE;
    // Compressed/non-32-bit encodings are never decoded, whatever the opcode.
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        OP_OP:                                fmt = FMT_R;
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  fmt = FMT_I;
        OP_STORE:                             fmt = FMT_S;
        OP_BRANCH:                            fmt = FMT_B;
        OP_LUI, OP_AUIPC:                     fmt = FMT_U;
        OP_JAL:                               fmt = FMT_J;
        OP_IMM_32: if (XLEN == 64)            fmt = FMT_I;
        OP_32:     if (XLEN == 64)            fmt = FMT_R;
        default:                              fmt = FMT_NONE;
      endcase
    end
  end

  // Sized casts of signed operands sign-extend straight to XLEN.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = XLEN'($signed(inst[31:20]));
      FMT_S: imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      FMT_B: imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      FMT_U: imm = XLEN'($signed({inst[31:12], 12'b0}));
      FMT_J: imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

  always_comb begin
    illegal  = (fmt == FMT_NONE);
    rd_we    = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) &&
               (inst[11:7] != 5'd0);
    rs1_used = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B);
    rs2_used = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B);
  end

endmodule

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered RV32/RV64 instruction decode pipeline stage
//
// Purpose: accepts one instruction per cycle from fetch, decodes it and holds
// the result in output registers until the consumer takes it.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 drop held and incoming entries
//   in_valid/in_ready     fetch handshake; in_inst, in_pc payload
//   out_valid/out_ready   consumer handshake
//   out_pc                registered PC
//   opcode..func7         raw instruction fields
//   fmt, imm              format code and sign-extended immediate
//   rd_we, rs1_used,
//   rs2_used, illegal     register usage and illegal flags

module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      func3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      func7,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            rd_we,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic            illegal
);

  fmt_t            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rd_we;
  logic            dec_rs1_used;
  logic            dec_rs2_used;
  logic            dec_illegal;
  logic            accept;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst     (in_inst),
    .fmt      (dec_fmt),
    .imm      (dec_imm),
    .rd_we    (dec_rd_we),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used),
    .illegal  (dec_illegal)
  );

  // Ready passes through out_ready so a draining entry can be replaced in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      opcode    <= '0;
      rd        <= '0;
      func3     <= '0;
      rs1       <= '0;
      rs2       <= '0;
      func7     <= '0;
      fmt       <= FMT_NONE;
      imm       <= '0;
      rd_we     <= 1'b0;
      rs1_used  <= 1'b0;
      rs2_used  <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      opcode    <= in_inst[6:0];
      rd        <= in_inst[11:7];
      func3     <= in_inst[14:12];
      rs1       <= in_inst[19:15];
      rs2       <= in_inst[24:20];
      func7     <= in_inst[31:25];
      fmt       <= dec_fmt;
      imm       <= dec_imm;
      rd_we     <= dec_rd_we;
      rs1_used  <= dec_rs1_used;
      rs2_used  <= dec_rs2_used;
      illegal   <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - self-checking bench for rv_decode_stage

module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_pc;
  logic [6:0]  opcode, func7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  func3, fmt;
  logic [31:0] imm;
  logic        rd_we, rs1_used, rs2_used, illegal;

  logic        in_ready64, out_valid64;
  logic [31:0] out_pc64;
  logic [6:0]  opcode64, func7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  func3_64, fmt64;
  logic [63:0] imm64;
  logic        rd_we64, rs1_used64, rs2_used64, illegal64;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2),
    .func7(func7), .fmt(fmt), .imm(imm), .rd_we(rd_we), .rs1_used(rs1_used),
    .rs2_used(rs2_used), .illegal(illegal)
  );

  rv_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .opcode(opcode64), .rd(rd64), .func3(func3_64), .rs1(rs1_64),
    .rs2(rs2_64), .func7(func7_64), .fmt(fmt64), .imm(imm64), .rd_we(rd_we64),
    .rs1_used(rs1_used64), .rs2_used(rs2_used64), .illegal(illegal64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        rd_we, rs1u, rs2u, ill;
  } dec_t;

  // Reference decoder: classify by opcode, then build immediates numerically
  // (signed field value scaled by its implicit low zero bits).
  function automatic dec_t model(input logic [31:0] i, input bit x64);
    dec_t d;
    longint v;
    int f;
    f = 7;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'h33: f = 0;
        7'h13, 7'h03, 7'h67, 7'h73: f = 1;
        7'h23: f = 2;
        7'h63: f = 3;
        7'h37, 7'h17: f = 4;
        7'h6F: f = 5;
        7'h1B: f = x64 ? 1 : 7;
        7'h3B: f = x64 ? 0 : 7;
        default: f = 7;
      endcase
    end
    case (f)
      1: v = longint'($signed(i[31:20]));
      2: v = longint'($signed({i[31:25], i[11:7]}));
      3: v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
      4: v = longint'($signed(i[31:12])) * 4096;
      5: v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
      default: v = 0;
    endcase
    d.fmt   = 3'(f);
    d.imm   = x64 ? 64'(v) : {32'd0, v[31:0]};
    d.ill   = (f == 7);
    d.rd_we = (f == 0 || f == 1 || f == 4 || f == 5) && (i[11:7] != 5'd0);
    d.rs1u  = (f <= 3);
    d.rs2u  = (f == 0 || f == 2 || f == 3);
    return d;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        rd_we, rs1u, rs2u, ill;
    logic [2:0]  fmt64;
  } vec_t;

  vec_t vecs[$];

  logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                          7'h63, 7'h37, 7'h17, 7'h6F, 7'h1B, 7'h3B};

  bit    m_valid;
  dec_t  m_d32, m_d64;
  logic [31:0] m_inst, m_pc;

  initial begin
    vecs.push_back('{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1, 1, 0, 0, 3'd1});
    vecs.push_back('{32'h0020A423, 3'd2, 32'h00000008, 0, 1, 1, 0, 3'd2});
    vecs.push_back('{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 0, 1, 1, 0, 3'd3});
    vecs.push_back('{32'h123452B7, 3'd4, 32'h12345000, 1, 0, 0, 0, 3'd4});
    vecs.push_back('{32'h008000EF, 3'd5, 32'h00000008, 1, 0, 0, 0, 3'd5});
    vecs.push_back('{32'h002081B3, 3'd0, 32'h00000000, 1, 1, 1, 0, 3'd0});
    vecs.push_back('{32'h00000033, 3'd0, 32'h00000000, 0, 1, 1, 0, 3'd0});
    vecs.push_back('{32'h00000000, 3'd7, 32'h00000000, 0, 0, 0, 1, 3'd7});
    vecs.push_back('{32'h0000007F, 3'd7, 32'h00000000, 0, 0, 0, 1, 3'd7});
    vecs.push_back('{32'h0000009B, 3'd7, 32'h00000000, 0, 0, 0, 1, 3'd1});

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fmt", fmt, 7);
    chk("rst_imm", imm, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_flags", {rd_we, rs1_used, rs2_used, illegal}, 0);
    @(negedge clk); rst = 1'b0;

    // Table vectors, streamed back-to-back
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_inst  = vecs[k].inst;
      in_pc    = 32'h100 + 32'(k) * 4;
      #1 chk("tbl_in_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_out_pc", out_pc, 32'h100 + 32'(k) * 4);
      chk("tbl_fmt", fmt, vecs[k].fmt);
      chk("tbl_imm", imm, vecs[k].imm);
      chk("tbl_flags", {rd_we, rs1_used, rs2_used, illegal},
          {vecs[k].rd_we, vecs[k].rs1u, vecs[k].rs2u, vecs[k].ill});
      chk("tbl_fields", {func7, rs2, rs1, func3, rd, opcode}, vecs[k].inst);
      chk("tbl_fmt64", fmt64, vecs[k].fmt64);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1 chk("drain_out_valid", out_valid, 0);

    // Backpressure
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h200; out_ready = 1'b0;
    @(posedge clk); #1 chk("bp_first_valid", out_valid, 1);
    @(negedge clk); in_inst = 32'h0020A423; in_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_pc", out_pc, 32'h200);
      chk("bp_hold_imm", imm, 32'hFFFFFFFF);
      chk("bp_hold_fmt", fmt, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_new_pc", out_pc, 32'h204);
    chk("bp_new_fmt", fmt, 2);
    chk("bp_new_valid", out_valid, 1);

    // Flush beats accept and a stalled entry
    @(negedge clk);
    in_inst = 32'h123452B7; in_pc = 32'h208; out_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1 chk("flush_out_valid", out_valid, 0);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 chk("flush_no_entry", out_valid, 0);

    // Reset in the middle of a stall
    @(negedge clk); in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h300; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1 chk("rstmid_stall_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1 chk("rstmid_async_valid", out_valid, 0);
    chk("rstmid_fmt", fmt, 7);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rstmid_no_stale", out_valid, 0);

    // Randomized traffic against the model
    m_valid = 0;
    m_d32 = model(32'd0, 0);
    m_d64 = model(32'd0, 1);
    m_inst = '0;
    m_pc = '0;
    for (int n = 0; n < 400; n++) begin
      bit acc;
      bit exp_ready;
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_pc     = $urandom;
      in_inst   = $urandom;
      if ($urandom_range(0, 7) != 0) in_inst[6:0] = ops[$urandom_range(0, 11)];
      exp_ready = !m_valid || out_ready;
      #1 chk("rnd_in_ready", in_ready, exp_ready);
      acc = in_valid && exp_ready && !flush;
      @(posedge clk); #1;
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1;
        m_inst  = in_inst;
        m_pc    = in_pc;
        m_d32   = model(in_inst, 0);
        m_d64   = model(in_inst, 1);
      end else if (out_ready) m_valid = 0;
      chk("rnd_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("rnd_out_pc", out_pc, m_pc);
        chk("rnd_fields", {func7, rs2, rs1, func3, rd, opcode}, m_inst);
        chk("rnd_fmt", fmt, m_d32.fmt);
        chk("rnd_imm", imm, m_d32.imm);
        chk("rnd_flags", {rd_we, rs1_used, rs2_used, illegal},
            {m_d32.rd_we, m_d32.rs1u, m_d32.rs2u, m_d32.ill});
        chk("rnd_fmt64", fmt64, m_d64.fmt);
        chk("rnd_imm64", imm64, m_d64.imm);
        chk("rnd_flags64", {rd_we64, rs1_used64, rs2_used64, illegal64},
            {m_d64.rd_we, m_d64.rs1u, m_d64.rs2u, m_d64.ill});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
